mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 37 +++
 rtl/mem_stage.sv | 107 ++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX-to-MEM, data-memory and writeback signals of the memory stage
interface mem_stage_if;
  logic        ex_valid;
  logic [5:0]  ex_op;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_dest;
  logic        ex_zero;
  logic        flush;
  logic        mem_busy;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_regwrite;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        branch_taken;
  logic        mem_err;

  modport master (
    output ex_valid, ex_op, ex_alu_out, ex_wdata, ex_dest, ex_zero, flush,
    output dmem_ack, dmem_rdata,
    input  mem_busy, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  wb_valid, wb_regwrite, wb_data, wb_dest, branch_taken, mem_err
  );

  modport slave (
    input  ex_valid, ex_op, ex_alu_out, ex_wdata, ex_dest, ex_zero, flush,
    input  dmem_ack, dmem_rdata,
    output mem_busy, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output wb_valid, wb_regwrite, wb_data, wb_dest, branch_taken, mem_err
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: single outstanding lw/sw with ack timeout, ALU/branch pass-through to WB
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_stage_if.slave  bus
);
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_next;
  logic [3:0]  wait_cnt;
  logic [4:0]  dest_q;
  logic        load_q;
  logic        accept;
  logic        is_mem;
  logic        timeout_hit;

  function automatic logic writes_reg(input logic [5:0] op, input logic [4:0] dest);
    logic hit;
    case (op)
      6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23: hit = 1'b1;
      default:                                         hit = 1'b0;
    endcase
    return hit && (dest != 5'd0);
  endfunction

  assign bus.mem_busy = (state == ACCESS);
  assign accept       = bus.ex_valid & ~bus.flush & ~bus.mem_busy;
  assign is_mem       = (bus.ex_op == OP_LW) || (bus.ex_op == OP_SW);
  // The cycle whose missing ack would bring the wait count up to TIMEOUT aborts the access.
  assign timeout_hit  = (state == ACCESS) && !bus.dmem_ack &&
                        (({1'b0, wait_cnt} + 5'd1) == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mem)               state_next = ACCESS;
      ACCESS:  if (bus.dmem_ack || timeout_hit)    state_next = IDLE;
      default:                                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt         <= 4'd0;
      dest_q           <= 5'd0;
      load_q           <= 1'b0;
      bus.dmem_req     <= 1'b0;
      bus.dmem_we      <= 1'b0;
      bus.dmem_addr    <= 32'd0;
      bus.dmem_wdata   <= 32'd0;
      bus.wb_valid     <= 1'b0;
      bus.wb_regwrite  <= 1'b0;
      bus.wb_data      <= 32'd0;
      bus.wb_dest      <= 5'd0;
      bus.branch_taken <= 1'b0;
      bus.mem_err      <= 1'b0;
    end else begin
      bus.wb_valid     <= 1'b0;
      bus.branch_taken <= 1'b0;
      if (state == ACCESS) begin
        if (bus.dmem_ack) begin
          bus.dmem_req    <= 1'b0;
          bus.dmem_we     <= 1'b0;
          bus.wb_valid    <= 1'b1;
          bus.wb_dest     <= dest_q;
          bus.wb_regwrite <= load_q && (dest_q != 5'd0);
          bus.wb_data     <= load_q ? bus.dmem_rdata : bus.dmem_addr;
        end else if (timeout_hit) begin
          bus.dmem_req <= 1'b0;
          bus.dmem_we  <= 1'b0;
          bus.mem_err  <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end else if (accept) begin
        if (is_mem) begin
          bus.dmem_req   <= 1'b1;
          bus.dmem_we    <= (bus.ex_op == OP_SW);
          bus.dmem_addr  <= bus.ex_alu_out;
          bus.dmem_wdata <= (bus.ex_op == OP_SW) ? bus.ex_wdata : 32'd0;
          dest_q         <= bus.ex_dest;
          load_q         <= (bus.ex_op == OP_LW);
          wait_cnt       <= 4'd0;
        end else begin
          bus.wb_valid     <= 1'b1;
          bus.wb_data      <= bus.ex_alu_out;
          bus.wb_dest      <= bus.ex_dest;
          bus.wb_regwrite  <= writes_reg(bus.ex_op, bus.ex_dest);
          bus.branch_taken <= ((bus.ex_op == OP_BEQ) || (bus.ex_op == OP_BNE)) && bus.ex_zero;
        end
      end
    end
  end
endmodule
